// File: rtl/seqmul_if.sv
// Operand/result bundle between the main FSM and the iterative multiplier.
interface seqmul_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] AccHi;
  logic [WIDTH-1:0] AccLo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic             FlagN;
  logic             FlagZ;

  modport master (
    output Start, Mode, SrcA, SrcB, AccHi, AccLo,
    input  Busy, Done, ResultLo, ResultHi, FlagN, FlagZ
  );

  modport slave (
    input  Start, Mode, SrcA, SrcB, AccHi, AccLo,
    output Busy, Done, ResultLo, ResultHi, FlagN, FlagZ
  );
endinterface

// File: rtl/seqmul.sv
// Radix-2 shift-add multiply / multiply-accumulate; fixed WIDTH+2 cycle latency,
// Start ignored while busy, results held until the next operation completes.
module seqmul #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  seqmul_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         mode_q;
  logic [WIDTH-1:0]   acc_hi_q, acc_lo_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               flag_n, flag_z;
  logic               busy, done;

  logic               sgn_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix, acc_ext, fix_sum;
  logic [WIDTH-1:0]   lo_nxt, hi_nxt;
  logic               is_long;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = bus.Start ? RUN : IDLE;
      RUN:        if (cnt == CW'(1)) state_nxt = FIX;
      FIX:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  // Signed modes multiply magnitudes; the sign is restored in FIX.
  always_comb begin
    sgn_in = (bus.Mode[2:1] == 2'b11);
    a_mag  = (sgn_in && bus.SrcA[WIDTH-1]) ? (~bus.SrcA + 1'b1) : bus.SrcA;
    b_mag  = (sgn_in && bus.SrcB[WIDTH-1]) ? (~bus.SrcB + 1'b1) : bus.SrcB;
  end

  always_comb begin
    is_long  = mode_q[2];
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    acc_ext  = '0;
    if (mode_q[2] && mode_q[0]) acc_ext = {acc_hi_q, acc_lo_q};
    else if (mode_q == 3'b001)  acc_ext = {{WIDTH{1'b0}}, acc_lo_q};
    fix_sum  = prod_fix + acc_ext;
    lo_nxt   = fix_sum[WIDTH-1:0];
    hi_nxt   = is_long ? fix_sum[2*WIDTH-1:WIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      res_lo   <= '0;
      res_hi   <= '0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            mode_q   <= bus.Mode;
            acc_hi_q <= bus.AccHi;
            acc_lo_q <= bus.AccLo;
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            neg_q    <= sgn_in && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
            prod     <= '0;
            cnt      <= CW'(WIDTH);
          end
        end
        RUN: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
        end
        FIX: begin
          res_lo <= lo_nxt;
          res_hi <= hi_nxt;
          flag_n <= is_long ? hi_nxt[WIDTH-1] : lo_nxt[WIDTH-1];
          flag_z <= is_long ? ({hi_nxt, lo_nxt} == '0) : (lo_nxt == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.ResultLo = res_lo;
  assign bus.ResultHi = res_hi;
  assign bus.FlagN    = flag_n;
  assign bus.FlagZ    = flag_z;
endmodule

// File: tb/tb_seqmul.sv
// Directed checks of seqmul at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_seqmul;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seqmul_if #(.WIDTH(32)) m32 ();
  seqmul_if #(.WIDTH(8))  m8 ();

  seqmul #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(m32));
  seqmul #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(m8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op on the 32-bit unit; returns at the negedge of the Done cycle.
  task automatic run32(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input int ign_cyc,
                       output int done_cyc, output int busy_cnt);
    int cyc;
    @(negedge clk);
    m32.Mode = mode; m32.SrcA = a; m32.SrcB = b; m32.AccHi = hi; m32.AccLo = lo;
    m32.Start = 1'b1;
    @(negedge clk);
    m32.Start = 1'b0;
    m32.SrcA = ~a; m32.SrcB = ~b; m32.AccHi = ~hi; m32.AccLo = ~lo; m32.Mode = ~mode;
    cyc = 1; done_cyc = 0; busy_cnt = 0;
    while (cyc <= 60) begin
      if (m32.Busy) busy_cnt++;
      if (m32.Done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == ign_cyc) begin
        m32.Start = 1'b1; m32.Mode = 3'b100;
        m32.SrcA = 32'hDEADBEEF; m32.SrcB = 32'h12345678;
      end
      if (cyc == ign_cyc + 1) m32.Start = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run8(input logic [2:0] mode, input logic [7:0] a, input logic [7:0] b,
                      output int done_cyc);
    int cyc;
    @(negedge clk);
    m8.Mode = mode; m8.SrcA = a; m8.SrcB = b; m8.AccHi = '0; m8.AccLo = '0;
    m8.Start = 1'b1;
    @(negedge clk);
    m8.Start = 1'b0;
    m8.SrcA = ~a; m8.SrcB = ~b;
    cyc = 1; done_cyc = 0;
    while (cyc <= 30) begin
      if (m8.Done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int dc, bc, dc1, dc2, cyc, ndone;
    m32.Start = 0; m32.Mode = 0; m32.SrcA = 0; m32.SrcB = 0; m32.AccHi = 0; m32.AccLo = 0;
    m8.Start = 0;  m8.Mode = 0;  m8.SrcA = 0;  m8.SrcB = 0;  m8.AccHi = 0;  m8.AccLo = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctl32", {m32.Busy, m32.Done, m32.FlagN, m32.FlagZ}, 64'h0);
    chk("rst_res32", {m32.ResultHi, m32.ResultLo}, 64'h0);
    chk("rst_ctl8", {m8.Busy, m8.Done, m8.FlagN, m8.FlagZ, m8.ResultHi, m8.ResultLo}, 64'h0);
    reset = 1'b0;

    run32(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, dc, bc);
    chk("umull_lat", dc, 34);
    chk("umull_busy", bc, 33);
    chk("umull_res", {m32.ResultHi, m32.ResultLo}, 64'hFFFFFFFE_00000001);
    chk("umull_flg", {m32.FlagN, m32.FlagZ}, 2'b10);
    repeat (5) @(negedge clk);
    chk("hold_res", {m32.ResultHi, m32.ResultLo}, 64'hFFFFFFFE_00000001);
    chk("hold_ctl", {m32.Busy, m32.Done, m32.FlagN, m32.FlagZ}, 4'b0010);

    run32(3'b110, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, dc, bc);
    chk("smull1_res", {m32.ResultHi, m32.ResultLo}, 64'h00000000_80000000);
    chk("smull1_flg", {m32.FlagN, m32.FlagZ}, 2'b00);

    run32(3'b110, 32'h80000000, 32'h80000000, 0, 0, 0, dc, bc);
    chk("smull2_res", {m32.ResultHi, m32.ResultLo}, 64'h40000000_00000000);
    chk("smull2_lat", dc, 34);

    run32(3'b111, 32'hFFFFFFFD, 32'h5, 32'h0, 32'hF, 0, dc, bc);
    chk("smlal_res", {m32.ResultHi, m32.ResultLo}, 64'h0);
    chk("smlal_flg", {m32.FlagN, m32.FlagZ}, 2'b01);

    run32(3'b001, 32'd7, 32'd6, 32'h5, 32'hFFFFFFD6, 0, dc, bc);
    chk("mla_res", {m32.ResultHi, m32.ResultLo}, 64'h0);
    chk("mla_flg", {m32.FlagN, m32.FlagZ}, 2'b01);

    run32(3'b010, 32'hFFFFFFFF, 32'h2, 32'h7, 32'h9, 0, dc, bc);
    chk("mul010_res", {m32.ResultHi, m32.ResultLo}, 64'h00000000_FFFFFFFE);
    chk("mul010_flg", {m32.FlagN, m32.FlagZ}, 2'b10);

    run32(3'b101, 32'd2, 32'd3, 32'h1, 32'hFFFFFFFF, 0, dc, bc);
    chk("umlal_res", {m32.ResultHi, m32.ResultLo}, 64'h00000002_00000005);

    run32(3'b000, 32'h10, 32'h20, 0, 0, 5, dc, bc);
    chk("ign_lat", dc, 34);
    chk("ign_res", {m32.ResultHi, m32.ResultLo}, 64'h00000000_00000200);
    @(negedge clk);
    chk("ign_idle", {m32.Busy, m32.Done}, 2'b00);

    // Start held high across DONE chains a second operation.
    @(negedge clk);
    m32.Mode = 3'b100; m32.SrcA = 32'd3; m32.SrcB = 32'd5; m32.AccHi = 0; m32.AccLo = 0;
    m32.Start = 1'b1;
    @(negedge clk);
    cyc = 1; dc1 = 0; dc2 = 0;
    while (cyc <= 100) begin
      if (dc1 != 0 && cyc == dc1 + 1) m32.Start = 1'b0;
      if (m32.Done) begin
        if (dc1 == 0) begin
          dc1 = cyc;
          chk("b2b_res1", {m32.ResultHi, m32.ResultLo}, 64'h0000000F);
          m32.Mode = 3'b110; m32.SrcA = 32'hFFFFFFFE; m32.SrcB = 32'd3;
        end else begin
          dc2 = cyc;
          break;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_lat1", dc1, 34);
    chk("b2b_gap", dc2 - dc1, 34);
    chk("b2b_res2", {m32.ResultHi, m32.ResultLo}, 64'hFFFFFFFF_FFFFFFFA);
    chk("b2b_flg2", {m32.FlagN, m32.FlagZ}, 2'b10);
    m32.Start = 1'b0;

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    m32.Mode = 3'b100; m32.SrcA = 32'hFFFFFFFF; m32.SrcB = 32'hFFFFFFFF;
    m32.Start = 1'b1;
    @(negedge clk);
    m32.Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_ctl", {m32.Busy, m32.Done, m32.FlagN, m32.FlagZ}, 64'h0);
    chk("mrst_res", {m32.ResultHi, m32.ResultLo}, 64'h0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      if (m32.Done) ndone++;
      @(negedge clk);
    end
    chk("mrst_nodone", ndone, 0);
    run32(3'b000, 32'd3, 32'd4, 0, 0, 0, dc, bc);
    chk("mrst_mul", {m32.ResultHi, m32.ResultLo}, 64'd12);
    chk("mrst_lat", dc, 34);

    run8(3'b110, 8'h80, 8'h7F, dc);
    chk("w8_smull_lat", dc, 10);
    chk("w8_smull_res", {m8.ResultHi, m8.ResultLo}, 16'hC080);
    chk("w8_smull_flg", {m8.FlagN, m8.FlagZ}, 2'b10);
    run8(3'b100, 8'hFF, 8'hFF, dc);
    chk("w8_umull_lat", dc, 10);
    chk("w8_umull_res", {m8.ResultHi, m8.ResultLo}, 16'hFE01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
